// File: rtl/reg_file.sv
// Architectural register file with rename tags: commit write-back, issue-time
// dependency tagging, flush of rename state, and two source-operand query ports.
module reg_file_entry #(
  parameter int ROB_ID_W = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rob_clear,
  input  logic                commit_hit,
  input  logic [ROB_ID_W-1:0] update_val_dep,
  input  logic [31:0]         update_val,
  input  logic                rename_hit,
  input  logic [ROB_ID_W-1:0] update_dep,
  output logic [31:0]         val,
  output logic                busy,
  output logic [ROB_ID_W-1:0] dep
);
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      val  <= '0;
      busy <= 1'b0;
      dep  <= '0;
    end else if (rdy_in) begin
      if (rob_clear) begin
        busy <= 1'b0;
        dep  <= '0;
      end else begin
        if (commit_hit) begin
          val <= update_val;
          // only the youngest writer's commit releases the register
          if (busy && dep == update_val_dep) busy <= 1'b0;
        end
        if (rename_hit) begin
          busy <= 1'b1;
          dep  <= update_dep;
        end
      end
    end
  end
endmodule

module reg_file #(
  parameter int REG_NUM  = 32,
  parameter int ROB_ID_W = 5
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                rob_clear,
  input  logic                is_update_val,
  input  logic [4:0]          update_val_id,
  input  logic [ROB_ID_W-1:0] update_val_dep,
  input  logic [31:0]         update_val,
  input  logic                is_update_dep,
  input  logic [4:0]          update_dep_id,
  input  logic [ROB_ID_W-1:0] update_dep,
  input  logic [4:0]          qry1_id,
  output logic                qry1_busy,
  output logic [ROB_ID_W-1:0] qry1_dep,
  output logic [31:0]         qry1_val,
  input  logic [4:0]          qry2_id,
  output logic                qry2_busy,
  output logic [ROB_ID_W-1:0] qry2_dep,
  output logic [31:0]         qry2_val
);
  typedef struct packed {
    logic                busy;
    logic [ROB_ID_W-1:0] dep;
    logic [31:0]         val;
  } qry_rsp_t;

  logic [REG_NUM-1:0][31:0]         val_q;
  logic [REG_NUM-1:0]               busy_q;
  logic [REG_NUM-1:0][ROB_ID_W-1:0] dep_q;

  genvar i;
  generate
    for (i = 0; i < REG_NUM; i++) begin : g_reg
      if (i == 0) begin : g_zero
        assign val_q[i]  = '0;
        assign busy_q[i] = 1'b0;
        assign dep_q[i]  = '0;
      end else begin : g_ent
        reg_file_entry #(.ROB_ID_W(ROB_ID_W)) u_ent (
          .clk_in         (clk_in),
          .rst_in         (rst_in),
          .rdy_in         (rdy_in),
          .rob_clear      (rob_clear),
          .commit_hit     (is_update_val && update_val_id == 5'(i)),
          .update_val_dep (update_val_dep),
          .update_val     (update_val),
          .rename_hit     (is_update_dep && update_dep_id == 5'(i)),
          .update_dep     (update_dep),
          .val            (val_q[i]),
          .busy           (busy_q[i]),
          .dep            (dep_q[i])
        );
      end
    end
  endgenerate

  // same-cycle rename is deliberately not bypassed; a matching commit is
  function automatic qry_rsp_t lookup(input logic [4:0] q);
    lookup = '0;
    if (q != '0) begin
      if (is_update_val && !rob_clear && update_val_id == q &&
          busy_q[q] && dep_q[q] == update_val_dep) begin
        lookup.val = update_val;
      end else begin
        lookup.busy = busy_q[q];
        lookup.dep  = dep_q[q];
        lookup.val  = val_q[q];
      end
    end
  endfunction

  qry_rsp_t rsp1, rsp2;
  assign rsp1 = lookup(qry1_id);
  assign rsp2 = lookup(qry2_id);

  assign qry1_busy = rsp1.busy;
  assign qry1_dep  = rsp1.dep;
  assign qry1_val  = rsp1.val;
  assign qry2_busy = rsp2.busy;
  assign qry2_dep  = rsp2.dep;
  assign qry2_val  = rsp2.val;
endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Architectural register file with rename tags. Sits directly downstream of the reorder buffer.
- Consumes the ROB's commit stream (value write-back) and issue stream (destination dependency tagging).
- Answers the decoder's two source-operand queries: either a ready value, or the ROB id that will produce it.
- Clears all rename state when the ROB signals a flush.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 is hardwired to zero.
- ROB_ID_W, 5, width of a ROB entry id; equals `ROB_SIZE_BIT.

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous active-high reset
- rdy_in  input  1  global ready; all state holds while low
- rob_clear  input  1  ROB flush: discard all rename tags
- is_update_val  input  1  commit write-back valid
- update_val_id  input  5  committed destination register
- update_val_dep  input  ROB_ID_W  ROB id of the committing entry
- update_val  input  32  committed value
- is_update_dep  input  1  new in-flight writer issued
- update_dep_id  input  5  destination register of the issued instruction
- update_dep  input  ROB_ID_W  ROB id allocated to the issued instruction
- qry1_id  input  5  decoder source register 1
- qry1_busy  output  1  rs1 has a pending writer
- qry1_dep  output  ROB_ID_W  ROB id of the pending writer (valid when busy)
- qry1_val  output  32  rs1 value (valid when not busy)
- qry2_id  input  5  decoder source register 2
- qry2_busy  output  1  as qry1
- qry2_dep  output  ROB_ID_W  as qry1
- qry2_val  output  32  as qry1

Behaviour:
- State per register i: val[i] (32 bits), busy[i] (1 bit), dep[i] (ROB_ID_W bits).
- Reset: on rising clk_in with rst_in=1, all val, busy and dep go to 0. Reset takes priority over rdy_in and every other input.
- Outputs are combinational from state. After reset every query returns busy=0, dep=0, val=0.
- rdy_in=0: no state change. Outputs still track the inputs combinationally.
- Flush cycle (rob_clear=1, rdy_in=1):
  - All busy[i] <= 0 and all dep[i] <= 0.
  - val is unchanged. Commit and rename inputs are ignored, because anything presented that cycle is wrong-path.
- Commit (is_update_val=1, no flush, update_val_id != 0):
  - val[id] <= update_val.
  - If busy[id]=1 and dep[id]==update_val_dep, then busy[id] <= 0. Otherwise busy/dep are untouched, since a younger writer still owns the register.
- Rename (is_update_dep=1, no flush, update_dep_id != 0): busy[id] <= 1, dep[id] <= update_dep.
- Same cycle, same register, commit + rename: val takes the commit value; busy=1 and dep=update_dep. Rename wins for busy/dep.
- Writes to x0 are discarded.
- Query for id q:
  - q==0: busy=0, dep=0, val=0.
  - Commit bypass: if is_update_val, !rob_clear, update_val_id==q, busy[q], and dep[q]==update_val_dep, return busy=0, val=update_val, dep=0.
  - Otherwise return busy[q], dep[q], val[q].
- Same-cycle rename of q is NOT bypassed to the query. The decoder reads sources before renaming its own destination, so an instruction like add x5,x5,x6 sees the prior x5 mapping.
- Query and flush in the same cycle: return the stored state. The decoder discards the instruction on flush.
- Two query ports are independent and may name the same register.
- No handshakes. One update of each kind per cycle. Latency: written state is visible to queries from the next cycle; a matching commit is visible in the same cycle through the bypass.

Test Plan:
- Reset, then query x3 and x0 -> busy=0, val=0 on both ports.
- Rename x5 to tag 7; next cycle query x5 -> busy=1, dep=7. Commit x5, dep 7, value 0x1234 -> in that same cycle query returns busy=0, val=0x1234. The cycle after, stored val=0x1234, busy=0.
- Rename x5 to tag 7, then rename x5 to tag 9. Commit x5, dep 7, value 0xAA -> val[5]=0xAA but busy stays 1, dep=9. The query bypass does not fire.
- Same cycle: commit x8 (dep 3, value 0x55) and rename x8 to tag 4 -> next cycle busy=1, dep=4, val=0x55. A query during that cycle returns the committed value with busy=0, since the rename is not bypassed.
- Rename x1, x2 and x31 to tags 1, 2, 3, then assert rob_clear together with a commit to x1 -> next cycle all three are busy=0 and val[1] is unchanged.
- Rename and commit to x0 (value 0xFFFF) -> x0 always reads busy=0, val=0. With rdy_in=0, rename x4 -> no state change.
